// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared state encoding, mode constants and one-hot helper for scan_decoder.
package scan_decoder_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    localparam int unsigned MAX_OUT = 256;

    // Callers size-cast the result down to their own output width.
    function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_OUT-1:0] one;
        one = {{(MAX_OUT-1){1'b0}}, 1'b1};
        return (idx < n) ? (one << idx) : '0;
    endfunction

endpackage

// File: rtl/scan_decoder_timer.sv
// scan_decoder_timer: dwell counter and output index counter with a registered wrap pulse.
module scan_decoder_timer #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned DWELL   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             run,
    input  logic             load,
    input  logic [SEL_W-1:0] load_idx,
    output logic [SEL_W-1:0] idx,
    output logic [SEL_W-1:0] idx_next,
    output logic             wrap
);
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OUT - 1);

    logic [CNT_W-1:0] cnt, cnt_d;
    logic dwell_end, wrap_d;

    always_comb begin
        dwell_end = cnt == CNT_W'(DWELL - 1);
        idx_next  = restart ? '0 :
                    load ? load_idx :
                    (run && dwell_end) ? ((idx == LAST) ? '0 : idx + 1'b1) : idx;
        cnt_d     = (restart || load) ? '0 :
                    run ? (dwell_end ? '0 : cnt + 1'b1) : cnt;
        wrap_d    = run && !restart && !load && dwell_end && idx == LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            idx  <= idx_next;
            cnt  <= cnt_d;
            wrap <= wrap_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with DIRECT (handshaked) and SCAN (auto-cycling) modes.
// Define SCAN_DECODER_ERR_EN to add the sticky out-of-range err output.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned NUM_OUT    = 8,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] y,
    output logic               y_valid,
    output logic [SEL_W-1:0]   scan_idx,
`ifdef SCAN_DECODER_ERR_EN
    output logic               err,
`endif
    output logic               wrap
);
    localparam logic [NUM_OUT-1:0] Y_IDLE = ACTIVE_LOW ? '1 : '0;

    state_t state, state_d;
    logic accept, restart, run, valid_d;
    logic [SEL_W-1:0] idx_next;
    logic [NUM_OUT-1:0] hot_d;

    always_comb begin
        in_ready = en && mode == MODE_DIRECT && state != SCAN;
        accept   = in_valid && in_ready;
        restart  = en && mode == MODE_SCAN && state != SCAN;
        run      = en && mode == MODE_SCAN && state == SCAN;
        state_d  = !en ? IDLE :
                   (mode == MODE_SCAN) ? SCAN :
                   (state == SCAN || accept) ? HOLD : state;
        // Dropping out of SCAN blanks the outputs until a fresh select is accepted.
        valid_d  = !en ? 1'b0 :
                   (mode == MODE_SCAN) ? 1'b1 :
                   (state == SCAN) ? 1'b0 :
                   accept ? 1'b1 : y_valid;
        hot_d    = valid_d ? NUM_OUT'(onehot(32'(idx_next), NUM_OUT)) : '0;
    end

    scan_decoder_timer #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT), .DWELL(DWELL)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .run      (run),
        .load     (accept),
        .load_idx (sel),
        .idx      (scan_idx),
        .idx_next (idx_next),
        .wrap     (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            y       <= Y_IDLE;
            y_valid <= 1'b0;
        end else begin
            state   <= state_d;
            y       <= ACTIVE_LOW ? ~hot_d : hot_d;
            y_valid <= valid_d;
        end
    end

`ifdef SCAN_DECODER_ERR_EN
    logic oor;
    assign oor = {1'b0, sel} >= (SEL_W + 1)'(NUM_OUT);

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (accept && oor)
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed vectors for an 8-output active-high and a 6-output active-low DWELL=1 decoder.
module tb_scan_decoder;

    logic clk = 1'b0;
    logic rst, en, mode, in_valid;
    logic [2:0] sel;
    logic rdy_a, rdy_b, val_a, val_b, wrap_a, wrap_b;
    logic [7:0] y_a;
    logic [5:0] y_b;
    logic [2:0] idx_a, idx_b;
`ifdef SCAN_DECODER_ERR_EN
    logic err_a, err_b;
`endif
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .NUM_OUT(8), .DWELL(4), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy_a),
        .sel(sel), .y(y_a), .y_valid(val_a), .scan_idx(idx_a),
`ifdef SCAN_DECODER_ERR_EN
        .err(err_a),
`endif
        .wrap(wrap_a)
    );

    scan_decoder #(.SEL_W(3), .NUM_OUT(6), .DWELL(1), .ACTIVE_LOW(1'b1)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy_b),
        .sel(sel), .y(y_b), .y_valid(val_b), .scan_idx(idx_b),
`ifdef SCAN_DECODER_ERR_EN
        .err(err_b),
`endif
        .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; sel = 3'd0;
        tick; tick;
        check("rst y_a", 32'(y_a), 32'h00);
        check("rst val_a", 32'(val_a), 0);
        check("rst idx_a", 32'(idx_a), 0);
        check("rst wrap_a", 32'(wrap_a), 0);
        check("rst y_b", 32'(y_b), 32'h3F);
`ifdef SCAN_DECODER_ERR_EN
        check("rst err_b", 32'(err_b), 0);
`endif
        rst = 1'b0; en = 1'b1; in_valid = 1'b1; sel = 3'd5;
        #1 check("rdy idle", 32'(rdy_a), 1);
        tick;
        check("dir5 y_a", 32'(y_a), 32'h20);
        check("dir5 val_a", 32'(val_a), 1);
        check("dir5 idx_a", 32'(idx_a), 5);
        check("dir5 y_b", 32'(y_b), 32'h1F);
        sel = 3'd0;
        tick;
        check("dir0 y_a", 32'(y_a), 32'h01);
        check("dir0 y_b", 32'(y_b), 32'h3E);
        in_valid = 1'b0; mode = 1'b1;
        tick;
        check("scan0 y_a", 32'(y_a), 32'h01);
        check("scan0 val_a", 32'(val_a), 1);
        check("scan0 rdy_a", 32'(rdy_a), 0);
        check("scan0 wrap_a", 32'(wrap_a), 0);
        check("scan0 y_b", 32'(y_b), 32'h3E);
        for (int k = 1; k <= 45; k++) begin
            tick;
            check($sformatf("scan y_a k%0d", k), 32'(y_a), 32'h1 << ((k / 4) % 8));
            check($sformatf("scan wrap_a k%0d", k), 32'(wrap_a), 32'(k % 32 == 0));
            check($sformatf("scan y_b k%0d", k), 32'(y_b), ~(32'h1 << (k % 6)) & 32'h3F);
            check($sformatf("scan wrap_b k%0d", k), 32'(wrap_b), 32'(k % 6 == 0));
        end
        mode = 1'b0;
        tick;
        check("hold y_a", 32'(y_a), 32'h00);
        check("hold val_a", 32'(val_a), 0);
        check("hold idx_a", 32'(idx_a), 3);
        check("hold rdy_a", 32'(rdy_a), 1);
        check("hold y_b", 32'(y_b), 32'h3F);
        mode = 1'b1;
        tick;
        check("rescan y_a", 32'(y_a), 32'h01);
        check("rescan idx_a", 32'(idx_a), 0);
        tick; tick; tick; tick;
        check("rescan4 y_a", 32'(y_a), 32'h02);
        en = 1'b0; mode = 1'b0;
        tick;
        check("off y_a", 32'(y_a), 32'h00);
        check("off val_a", 32'(val_a), 0);
        check("off idx_a", 32'(idx_a), 1);
        check("off idx_b", 32'(idx_b), 4);
        check("off rdy_a", 32'(rdy_a), 0);
        en = 1'b1; in_valid = 1'b1; sel = 3'd7;
        tick;
        check("sel7 y_a", 32'(y_a), 32'h80);
        check("sel7 y_b", 32'(y_b), 32'h3F);
        check("sel7 val_b", 32'(val_b), 1);
        check("sel7 idx_b", 32'(idx_b), 7);
`ifdef SCAN_DECODER_ERR_EN
        check("sel7 err_b", 32'(err_b), 1);
        check("sel7 err_a", 32'(err_a), 0);
`endif
        sel = 3'd2;
        tick;
        check("sel2 y_a", 32'(y_a), 32'h04);
        check("sel2 y_b", 32'(y_b), 32'h3B);
`ifdef SCAN_DECODER_ERR_EN
        check("sel2 err_b", 32'(err_b), 1);
`endif
        in_valid = 1'b0; mode = 1'b1;
        tick;
        check("prerst y_a", 32'(y_a), 32'h01);
        rst = 1'b1;
        tick;
        check("rstscan y_a", 32'(y_a), 32'h00);
        check("rstscan val_a", 32'(val_a), 0);
        check("rstscan y_b", 32'(y_b), 32'h3F);
        mode = 1'b0; in_valid = 1'b1; sel = 3'd5;
        tick;
        check("rstacc y_a", 32'(y_a), 32'h00);
        check("rstacc val_a", 32'(val_a), 0);
        check("rstacc idx_a", 32'(idx_a), 0);
`ifdef SCAN_DECODER_ERR_EN
        check("rstacc err_b", 32'(err_b), 0);
`endif
        rst = 1'b0;
        tick;
        check("post y_a", 32'(y_a), 32'h20);
        check("post idx_a", 32'(idx_a), 5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
